// File: rtl/qscan_pkg.sv
// rtl/qscan_pkg.sv - shared types, constants and helpers for the Q-value scanner
package qscan_pkg;

  localparam int Q_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Limit the requested entry count to the table depth so the index never wraps.
  function automatic int unsigned clamp_count(input int unsigned cnt, input int unsigned depth);
    return (cnt > depth) ? depth : cnt;
  endfunction

endpackage

// File: rtl/comparator16bit.sv
// rtl/comparator16bit.sv - 16-bit unsigned magnitude comparator
module comparator16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        A_grt_B,
  output logic        A_eq_B,
  output logic        A_lst_B
);

  assign A_grt_B = (A > B);
  assign A_eq_B  = (A == B);
  assign A_lst_B = (A < B);

endmodule

// File: rtl/qval_argmax_scan.sv
// rtl/qval_argmax_scan.sv - sequential argmax scan over a synchronous-read Q-table
// Define ARGMIN_EN to report the minimum entry instead of the maximum.
module qval_argmax_scan
  import qscan_pkg::*;
#(
  parameter int IDX_W  = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W:0]    count,
  output logic              mem_rd_en,
  output logic [IDX_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy,
  output logic              done,
  output logic              result_valid,
  output logic [DATA_W-1:0] best_val,
  output logic [IDX_W-1:0]  best_idx
);

  if (DATA_W != Q_DATA_W) begin : g_bad_width
    $error("qval_argmax_scan: DATA_W must be 16 to match comparator16bit");
  end

  localparam int unsigned DEPTH = 1 << IDX_W;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W:0]      n_q, n_d;
  logic [DATA_W-1:0]   best_val_q, best_val_d;
  logic [IDX_W-1:0]    best_idx_q, best_idx_d;
  logic                rv_q, rv_d;

  logic [IDX_W:0]      n_clamped;
  logic                last_entry;
  logic                a_grt_b, a_eq_b, a_lst_b;
  logic                replace;
  logic                unused_cmp;

  comparator16bit u_cmp (
    .A       (mem_rd_data),
    .B       (best_val_q),
    .A_grt_B (a_grt_b),
    .A_eq_B  (a_eq_b),
    .A_lst_B (a_lst_b)
  );

  // Strict compare in either build, so ties keep the lower index.
`ifdef ARGMIN_EN
  assign replace    = a_lst_b;
  assign unused_cmp = a_grt_b ^ a_eq_b;
`else
  assign replace    = a_grt_b;
  assign unused_cmp = a_eq_b ^ a_lst_b;
`endif

  assign n_clamped  = (IDX_W+1)'(clamp_count(32'(count), DEPTH));
  assign last_entry = ({1'b0, idx_q} == (n_q - 1'b1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (n_clamped == '0) ? DONE : READ;
      READ:    state_d = CMP;
      CMP:     state_d = last_entry ? DONE : READ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en = (state_q == READ);
    busy      = (state_q == READ) || (state_q == CMP);
    done      = (state_q == DONE);
  end

  always_comb begin
    idx_d      = idx_q;
    n_d        = n_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    rv_d       = rv_q;
    if (state_q == IDLE && start) begin
      n_d   = n_clamped;
      idx_d = '0;
      rv_d  = 1'b0;
    end else if (state_q == CMP) begin
      if (idx_q == '0 || replace) begin
        best_val_d = mem_rd_data;
        best_idx_d = idx_q;
      end
      if (last_entry) rv_d  = 1'b1;
      else            idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      n_q        <= '0;
      best_val_q <= '0;
      best_idx_q <= '0;
      rv_q       <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      n_q        <= n_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
      rv_q       <= rv_d;
    end
  end

  assign mem_addr     = idx_q;
  assign best_val     = best_val_q;
  assign best_idx     = best_idx_q;
  assign result_valid = rv_q;

endmodule

// File: tb/tb_qval_argmax_scan.sv
// tb/tb_qval_argmax_scan.sv - self-checking bench for qval_argmax_scan
module tb_qval_argmax_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  count = '0;
  logic        mem_rd_en;
  logic [3:0]  mem_addr;
  logic [15:0] mem_rd_data = '0;
  logic        busy, done, result_valid;
  logic [15:0] best_val;
  logic [3:0]  best_idx;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [16];
  int          addr_q[$];
  logic [15:0] exp_val = '0;
  int          exp_idx = 0;
  logic        exp_rv  = 1'b0;

  qval_argmax_scan #(.IDX_W(4), .DATA_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .count        (count),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_data  (mem_rd_data),
    .busy         (busy),
    .done         (done),
    .result_valid (result_valid),
    .best_val     (best_val),
    .best_idx     (best_idx)
  );

  always #5 clk = ~clk;

  // RAM model: data captured during the read cycle stays stable through the compare edge.
  always @(negedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data <= mem[mem_addr];
      addr_q.push_back(int'(mem_addr));
    end
  end

  // Reference: best of the first min(n,16) entries, first occurrence wins.
  task automatic model_scan(input int n);
    int nn;
    nn = (n > 16) ? 16 : n;
    exp_rv = (nn > 0);
    for (int i = 0; i < nn; i++) begin
`ifdef ARGMIN_EN
      if (i == 0 || mem[i] < exp_val) begin
`else
      if (i == 0 || mem[i] > exp_val) begin
`endif
        exp_val = mem[i];
        exp_idx = i;
      end
    end
  endtask

  task automatic run_scan(input int cnt, output int lat);
    logic [31:0] c;
    c = cnt;
    addr_q.delete();
    @(negedge clk);
    start = 1'b1;
    count = c[4:0];
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL scan_timeout: no done within %0d cycles (count=%0d)", lat, cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, mem_rd_en, result_valid} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got busy/done/rd_en/rv=%b required 0000", {busy, done, mem_rd_en, result_valid});
    end
    checks++;
    if ({best_val, best_idx, mem_addr} !== 24'h0) begin
      errors++;
      $display("FAIL reset_data: got val=%h idx=%0d addr=%0d required 0", best_val, best_idx, mem_addr);
    end
    rst = 1'b0;
    exp_val = '0; exp_idx = 0; exp_rv = 1'b0;
  endtask

  task automatic test_tie();
    int lat;
    mem[0] = 16'd5; mem[1] = 16'd900; mem[2] = 16'd12; mem[3] = 16'd900;
    run_scan(4, lat);
    model_scan(4);
    checks++;
    if (best_val !== exp_val || best_idx !== exp_idx[3:0] || result_valid !== 1'b1) begin
      errors++;
      $display("FAIL tie_result: got val=%0d idx=%0d rv=%b required val=%0d idx=%0d rv=1", best_val, best_idx, result_valid, exp_val, exp_idx);
    end
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL tie_latency: got %0d required 9", lat);
    end
    checks++;
    if (addr_q.size() != 4) begin
      errors++;
      $display("FAIL tie_reads: got %0d reads required 4", addr_q.size());
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tie_done_pulse: got done=%b busy=%b one cycle later required 0 0", done, busy);
    end
  endtask

  task automatic test_zero_count();
    int lat;
    run_scan(0, lat);
    model_scan(0);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL zero_latency: got %0d required 1", lat);
    end
    checks++;
    if (result_valid !== 1'b0 || addr_q.size() != 0) begin
      errors++;
      $display("FAIL zero_rv_reads: got rv=%b reads=%0d required rv=0 reads=0", result_valid, addr_q.size());
    end
    checks++;
    if (best_val !== exp_val || best_idx !== exp_idx[3:0]) begin
      errors++;
      $display("FAIL zero_hold: got val=%h idx=%0d required val=%h idx=%0d", best_val, best_idx, exp_val, exp_idx);
    end
  endtask

  task automatic test_clamp();
    int lat;
    int bad;
    for (int i = 0; i < 15; i++) mem[i] = 16'($urandom_range(0, 16'hFFFE));
    mem[15] = 16'hFFFF;
    run_scan(20, lat);
    model_scan(20);
    bad = 0;
    for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] != i) bad++;
    checks++;
    if (addr_q.size() != 16 || bad != 0) begin
      errors++;
      $display("FAIL clamp_reads: got %0d reads (%0d wrong addr) required 16 reads 0..15", addr_q.size(), bad);
    end
    checks++;
    if (best_val !== exp_val || best_idx !== exp_idx[3:0] || result_valid !== 1'b1 || lat !== 33) begin
      errors++;
      $display("FAIL clamp_result: got val=%h idx=%0d rv=%b lat=%0d required val=%h idx=%0d rv=1 lat=33", best_val, best_idx, result_valid, lat, exp_val, exp_idx);
    end
  endtask

  task automatic test_all_zero();
    int lat;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    run_scan(3, lat);
    model_scan(3);
    checks++;
    if (best_val !== 16'h0 || best_idx !== 4'd0 || result_valid !== 1'b1 || lat !== 7) begin
      errors++;
      $display("FAIL all_zero: got val=%h idx=%0d rv=%b lat=%0d required val=0 idx=0 rv=1 lat=7", best_val, best_idx, result_valid, lat);
    end
  endtask

  task automatic test_cost_table();
    int lat;
    mem[0] = 16'd40; mem[1] = 16'd7; mem[2] = 16'd7; mem[3] = 16'd300;
    run_scan(4, lat);
    model_scan(4);
    checks++;
    if (best_val !== exp_val || best_idx !== exp_idx[3:0]) begin
      errors++;
      $display("FAIL cost_table: got val=%0d idx=%0d required val=%0d idx=%0d", best_val, best_idx, exp_val, exp_idx);
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
    addr_q.delete();
    @(negedge clk);
    start = 1'b1; count = 5'd6;
    @(negedge clk);
    start = 1'b0; lat = 1;
    while (!done && lat < 100) begin
      if (lat == 3) begin start = 1'b1; count = 5'd2; end
      else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    model_scan(6);
    checks++;
    if (lat !== 13 || best_val !== exp_val || best_idx !== exp_idx[3:0] || addr_q.size() != 6) begin
      errors++;
      $display("FAIL busy_start: got lat=%0d val=%h idx=%0d reads=%0d required lat=13 val=%h idx=%0d reads=6", lat, best_val, best_idx, addr_q.size(), exp_val, exp_idx);
    end
    start = 1'b1; count = 5'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || mem_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL done_start: got busy=%b done=%b rd_en=%b required 0 0 0", busy, done, mem_rd_en);
    end
  endtask

  task automatic test_reset_mid_scan();
    int seen;
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
    @(negedge clk);
    start = 1'b1; count = 5'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || mem_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL mid_cmp_state: got busy=%b rd_en=%b required 1 0", busy, mem_rd_en);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, mem_rd_en, result_valid, best_val, best_idx, mem_addr} !== 28'h0) begin
      errors++;
      $display("FAIL mid_reset: got busy=%b done=%b rd_en=%b rv=%b val=%h idx=%0d addr=%0d required all 0", busy, done, mem_rd_en, result_valid, best_val, best_idx, mem_addr);
    end
    seen = 0;
    repeat (14) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL mid_reset_quiet: got %0d active cycles after reset required 0", seen);
    end
    exp_val = '0; exp_idx = 0; exp_rv = 1'b0;
  endtask

  task automatic test_random();
    int lat, cnt, nn, bad;
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 16; i++)
        mem[i] = (t % 2 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      cnt = $urandom_range(0, 20);
      nn = (cnt > 16) ? 16 : cnt;
      run_scan(cnt, lat);
      model_scan(cnt);
      bad = 0;
      for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] != i) bad++;
      checks++;
      if (best_val !== exp_val || best_idx !== exp_idx[3:0] || result_valid !== exp_rv) begin
        errors++;
        $display("FAIL rand_result[%0d]: count=%0d got val=%h idx=%0d rv=%b required val=%h idx=%0d rv=%b", t, cnt, best_val, best_idx, result_valid, exp_val, exp_idx, exp_rv);
      end
      checks++;
      if (lat != ((nn == 0) ? 1 : 2 * nn + 1) || addr_q.size() != nn || bad != 0) begin
        errors++;
        $display("FAIL rand_timing[%0d]: count=%0d got lat=%0d reads=%0d badaddr=%0d required lat=%0d reads=%0d", t, cnt, lat, addr_q.size(), bad, (nn == 0) ? 1 : 2 * nn + 1, nn);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_tie();
    test_zero_count();
    test_clamp();
    test_all_zero();
    test_cost_table();
    test_start_while_busy();
    test_reset_mid_scan();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
